// File: rtl/pool1_sched.sv
// pool1_sched: sequencing controller for the layer-1 pooling stage.
//   Forwards a valid/ready conv-output stream to four pool lanes through a
//   1-cycle register, runs the lanes one channel group at a time (flushing
//   them by dropping pool_en between groups), numbers pooled results into
//   contiguous output-buffer write addresses, checks the per-group result
//   count and pulses done at completion.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   start, abort                    begin a job (IDLE only) / return to IDLE
//   cfg_rows, cfg_cols, cfg_groups  job geometry, latched on start
//   cfg_base                        first output-buffer write address
//   src_valid, src_ready, src_data  upstream beat handshake
//   pool_en, pool_valid_in          lane enable / lane input valid
//   pool_data, pool_col             lane input data / latched column count
//   pool_valid_out, pool_end        lane status (AND across lanes)
//   wr_en, wr_addr                  output-buffer write strobe / address
//   busy, done, err                 not IDLE / completion pulse / sticky error
// Optional: define POOL1_SCHED_PERF_EN to add perf_cycles and perf_stall.
module pool1_sched #(
   parameter int IN_W   = 192,
   parameter int DIM_W  = 16,
   parameter int GRP_W  = 8,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DIM_W-1:0]  cfg_rows,
   input  logic [DIM_W-1:0]  cfg_cols,
   input  logic [GRP_W-1:0]  cfg_groups,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic              src_valid,
   input  logic [IN_W-1:0]   src_data,
   output logic              src_ready,
   output logic              pool_en,
   output logic              pool_valid_in,
   output logic [IN_W-1:0]   pool_data,
   output logic [DIM_W-1:0]  pool_col,
   input  logic              pool_valid_out,
   input  logic              pool_end,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              busy,
   output logic              done,
`ifdef POOL1_SCHED_PERF_EN
   output logic [31:0]       perf_cycles,
   output logic [31:0]       perf_stall,
`endif
   output logic              err
);
   localparam int CW = 2 * DIM_W;
   typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;
   state_t            state;
   logic [DIM_W-1:0]  rows, cols;
   logic [GRP_W-1:0]  groups, grp;
   logic [ADDR_W-1:0] base, total_out_cnt;
   logic [CW-1:0]     in_cnt, grp_out_cnt, beats, exp_out, grp_out_now;
   logic              kill, cfg_zero;
   assign beats       = CW'(rows) * CW'(cols);
   assign exp_out     = CW'(rows >> 1) * CW'(cols >> 1);
   // a result arriving together with pool_end still belongs to this group
   assign grp_out_now = grp_out_cnt + CW'(pool_valid_out);
   assign kill        = abort && state != IDLE;
   assign cfg_zero    = cfg_rows == '0 || cfg_cols == '0 || cfg_groups == '0;
   assign busy        = state != IDLE;
   assign done        = state == DONE;
   assign src_ready   = state == RUN;
   assign pool_en     = state == RUN || state == DRAIN;
   assign pool_col    = cols;
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rows          <= '0;
         cols          <= '0;
         groups        <= '0;
         base          <= '0;
         grp           <= '0;
         in_cnt        <= '0;
         grp_out_cnt   <= '0;
         total_out_cnt <= '0;
         pool_valid_in <= 1'b0;
         pool_data     <= '0;
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         err           <= 1'b0;
`ifdef POOL1_SCHED_PERF_EN
         perf_cycles   <= '0;
         perf_stall    <= '0;
`endif
      end else begin
         pool_valid_in <= 1'b0;
         wr_en         <= 1'b0;
         if (kill) begin
            state <= IDLE;
         end else begin
            // lanes have been flushed in IDLE/CLR, so a result there is bogus
            if (pool_valid_out) begin
               if (state == IDLE || state == CLR) err <= 1'b1;
               else begin
                  wr_en         <= 1'b1;
                  wr_addr       <= base + total_out_cnt;
                  total_out_cnt <= total_out_cnt + ADDR_W'(1);
                  grp_out_cnt   <= grp_out_cnt + CW'(1);
               end
            end
            if (pool_end && state == RUN) err <= 1'b1;
            case (state)
               IDLE: if (start) begin
                  rows          <= cfg_rows;
                  cols          <= cfg_cols;
                  groups        <= cfg_groups;
                  base          <= cfg_base;
                  grp           <= '0;
                  total_out_cnt <= '0;
                  err           <= cfg_zero;
                  state         <= cfg_zero ? DONE : CLR;
               end
               CLR: begin
                  in_cnt      <= '0;
                  grp_out_cnt <= '0;
                  state       <= RUN;
               end
               RUN: if (src_valid) begin
                  pool_data     <= src_data;
                  pool_valid_in <= 1'b1;
                  in_cnt        <= in_cnt + CW'(1);
                  if (in_cnt == beats - CW'(1)) state <= DRAIN;
               end
               DRAIN: if (pool_end) begin
                  if (grp_out_now != exp_out) err <= 1'b1;
                  if (grp == groups - GRP_W'(1)) state <= DONE;
                  else begin
                     grp   <= grp + GRP_W'(1);
                     state <= CLR;
                  end
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
`ifdef POOL1_SCHED_PERF_EN
         if (state == IDLE) begin
            if (start) begin
               perf_cycles <= '0;
               perf_stall  <= '0;
            end
         end else begin
            if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if (state == RUN && !src_valid && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
         end
`endif
      end
   end
endmodule

// File: tb/tb_pool1_sched.sv
// tb_pool1_sched: randomized self-checking bench for pool1_sched.
module tb_pool1_sched;
   localparam int IN_W = 192;
   logic            clk = 1'b0;
   logic            rst, start, abort, src_valid, pool_valid_out, pool_end;
   logic [15:0]     cfg_rows, cfg_cols, cfg_base;
   logic [7:0]      cfg_groups;
   logic [IN_W-1:0] src_data, pool_data;
   logic            src_ready, pool_en, pool_valid_in, wr_en, busy, done, err;
   logic [15:0]     pool_col, wr_addr;
   int              checks = 0, errors = 0;
   int              acc_cnt, wr_cnt, clr_len;
   logic [15:0]     next_addr;
   logic            acc_d, wexp_d, en_d;
   logic [IN_W-1:0] data_d;

   always #5 clk = ~clk;

   pool1_sched dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_groups(cfg_groups), .cfg_base(cfg_base),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .pool_en(pool_en), .pool_valid_in(pool_valid_in), .pool_data(pool_data), .pool_col(pool_col),
      .pool_valid_out(pool_valid_out), .pool_end(pool_end),
      .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done), .err(err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [IN_W-1:0] rnd_beat();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // What the spec says must show up one cycle after each edge.
   always @(posedge clk) begin
      acc_d  <= !rst && !abort && src_valid && src_ready;
      data_d <= src_data;
      wexp_d <= !rst && !abort && pool_valid_out && (pool_en || done);
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("pool_valid_in", pool_valid_in, acc_d);
         if (acc_d) begin
            check("pool_data", pool_data == data_d, 1);
            acc_cnt++;
         end
         check("wr_en", wr_en, wexp_d);
         if (wexp_d) begin
            check("wr_addr", wr_addr, next_addr);
            next_addr++;
            wr_cnt++;
         end
         if (busy && !pool_en && !done) clr_len++;
         else if (pool_en && !en_d) begin
            check("flush_len", clr_len, 1);
            clr_len = 0;
         end else if (!busy) clr_len = 0;
         en_d = pool_en;
      end
   end

   task automatic run_job(input int r, input int c, input int g, input logic [15:0] b,
                          input int gap, input int bad);
      int expo, nout, sent, guard, total;
      bit exp_err, ended;
      expo = (r / 2) * (c / 2);
      exp_err = 0;
      total = 0;
      cfg_rows = 16'(r); cfg_cols = 16'(c); cfg_groups = 8'(g); cfg_base = b;
      next_addr = b; acc_cnt = 0; wr_cnt = 0;
      start = 1; tick(); start = 0;
      check("busy_start", busy, 1);
      check("err_clear", err, 0);
      check("pool_col", pool_col, 64'(c));
      for (int gi = 0; gi < g; gi++) begin
         guard = 0;
         while (!src_ready && guard < 8) begin tick(); guard++; end
         check("run_entry", src_ready, 1);
         sent = 0; guard = 0;
         while (sent < r * c && guard < 4 * r * c + 8) begin
            src_valid = (gap == 0) || (gap == 1 && guard % 2 == 0) ||
                        (gap == 2 && $urandom_range(0, 1) == 1);
            src_data = rnd_beat();
            if (src_valid && src_ready) sent++;
            tick(); guard++;
         end
         check("beats", sent, r * c);
         src_valid = 1; src_data = rnd_beat();
         nout = (gi == bad) ? (expo > 0 ? expo - 1 : expo + 1) : expo;
         if (gi == bad) exp_err = 1;
         total += nout;
         ended = 0;
         for (int k = 0; k < nout; k++) begin
            repeat ($urandom_range(0, 1)) begin check("rdy_drain", src_ready, 0); tick(); end
            check("rdy_drain", src_ready, 0);
            pool_valid_out = 1;
            if (k == nout - 1 && $urandom_range(0, 1) == 1) begin pool_end = 1; ended = 1; end
            tick(); pool_valid_out = 0; pool_end = 0;
         end
         if (!ended) begin
            check("rdy_drain", src_ready, 0);
            pool_end = 1; tick(); pool_end = 0;
         end
         src_valid = 0;
         if (gi < g - 1) check("early_done", done, 0);
      end
      check("done", done, 1);
      check("err", err, exp_err);
      check("accepted", acc_cnt, r * c * g);
      tick();
      check("done_pulse", done, 0);
      check("idle", busy, 0);
      check("writes", wr_cnt, total);
   endtask

   initial begin
      int r, c, g;
      rst = 1; start = 0; abort = 0; src_valid = 0; pool_valid_out = 0; pool_end = 0;
      cfg_rows = 0; cfg_cols = 0; cfg_groups = 0; cfg_base = 0; src_data = '0;
      clr_len = 0; en_d = 0; acc_cnt = 0; wr_cnt = 0; next_addr = 0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_ready", src_ready, 0);
      check("rst_en", pool_en, 0);
      check("rst_pvi", pool_valid_in, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_col", pool_col, 0);
      rst = 0; tick();

      run_job(4, 4, 1, 16'h0100, 0, -1);
      run_job(2, 2, 3, 16'h0200, 0, -1);
      run_job(4, 4, 1, 16'h0300, 1, -1);
      run_job(4, 4, 1, 16'h0400, 0, 0);
      run_job(4, 4, 1, 16'hFFFE, 2, -1);

      for (int z = 0; z < 2; z++) begin
         cfg_rows = z == 0 ? 16'd4 : 16'd0; cfg_cols = 16'd4; cfg_groups = z == 0 ? 8'd0 : 8'd2;
         start = 1; tick(); start = 0;
         check("zero_done", done, 1);
         check("zero_err", err, 1);
         check("zero_en", pool_en, 0);
         tick();
         check("zero_pulse", done, 0);
         check("zero_busy", busy, 0);
      end

      cfg_rows = 4; cfg_cols = 4; cfg_groups = 1; cfg_base = 0;
      start = 1; tick(); start = 0;
      tick();
      check("abort_run", src_ready, 1);
      pool_end = 1; src_valid = 1; src_data = rnd_beat(); tick(); pool_end = 0;
      check("end_in_run_err", err, 1);
      check("end_in_run_state", src_ready, 1);
      abort = 1; src_data = rnd_beat(); tick(); abort = 0; src_valid = 0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_en", pool_en, 0);
      check("abort_ready", src_ready, 0);
      check("abort_err", err, 1);
      tick();
      check("abort_no_done", done, 0);
      run_job(4, 4, 1, 16'h0500, 0, -1);

      pool_valid_out = 1; tick(); pool_valid_out = 0;
      check("idle_pvo_err", err, 1);
      tick();
      check("idle_pvo_busy", busy, 0);

      cfg_rows = 3; cfg_cols = 3; cfg_groups = 1;
      start = 1; tick(); start = 0;
      tick();
      pool_end = 1; tick(); pool_end = 0;
      rst = 1; tick(); tick(); rst = 0;
      clr_len = 0;
      check("midrst_err", err, 0);
      check("midrst_busy", busy, 0);
      check("midrst_en", pool_en, 0);
      check("midrst_col", pool_col, 0);
      tick();

      for (int n = 0; n < 12; n++) begin
         r = $urandom_range(1, 5);
         c = $urandom_range(1, 5);
         g = $urandom_range(1, 3);
         run_job(r, c, g, 16'($urandom()), $urandom_range(0, 2),
                 $urandom_range(0, 2) == 0 ? int'($urandom_range(0, g - 1)) : -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired got running expected finished");
      $fatal(1);
   end
endmodule
